// File: rtl/axi_stream_insert_header_mb.sv
// Prepends a (possibly multi-beat) header frame to each AXI-Stream payload frame
// and repacks the merged MSB-first byte stream into dense output beats.
`timescale 1ns/1ps

module axi_stream_insert_header_mb #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic                    last_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);

  localparam int N  = DATA_BYTE_WD;
  localparam int CW = $clog2(N) + 1;  // holds r + q up to 2N-1
  localparam int RW = DATA_WD - 8;    // residual holds N-1 bytes, right-aligned

  typedef enum logic [1:0] {IDLE, HDR, DATA, FLUSH} state_t;

  function automatic logic [CW-1:0] popcnt(input logic [N-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CW'(k[i]);
    return c;
  endfunction

  function automatic logic [N-1:0] lead_ones(input logic [CW-1:0] n);
    return ~({N{1'b1}} >> n);
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [N-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < N; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       r_q, r_d, fcnt_q, fcnt_d;
  logic [RW-1:0]       res_q, res_d;
  logic                ov_q, ol_q;
  logic [DATA_WD-1:0]  od_q;
  logic [N-1:0]        ok_q;

  logic                free, hdr_acc, pay_acc;
  logic                ld, ld_last;
  logic [DATA_WD-1:0]  ld_data, beat, merged, flushed;
  logic [N-1:0]        ld_keep;
  logic [DATA_WD+RW-1:0] cat_sh;
  logic [CW-1:0]       p, q, sum;

  logic unused_cnt;
  assign unused_cnt = ^byte_insert_cnt;

  assign free         = !ov_q || ready_out;
  assign ready_insert = rst_n && free && (state_q == IDLE || state_q == HDR);
  assign ready_in     = rst_n && free && (state_q == DATA);
  assign hdr_acc      = valid_insert && ready_insert;
  assign pay_acc      = valid_in && ready_in;

  assign p   = popcnt(keep_insert);
  assign q   = popcnt(keep_in);
  assign sum = r_q + q;

  // Merge: output takes the r residual bytes followed by the top N-r bytes of the beat.
  assign beat    = (state_q == DATA) ? data_in : data_insert;
  assign cat_sh  = {res_q, beat} >> {r_q, 3'b000};
  assign merged  = cat_sh[DATA_WD-1:0];
  assign flushed = {8'h00, res_q} << {CW'(N) - r_q, 3'b000};

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    res_d   = res_q;
    fcnt_d  = fcnt_q;
    ld      = 1'b0;
    ld_data = '0;
    ld_keep = '0;
    ld_last = 1'b0;
    unique case (state_q)
      IDLE: if (hdr_acc) begin
        if (p == CW'(N)) begin
          ld      = 1'b1;
          ld_data = data_insert;
          ld_keep = '1;
          r_d     = '0;
        end else begin
          res_d = data_insert[RW-1:0];
          r_d   = p;
        end
        state_d = last_insert ? DATA : HDR;
      end
      HDR: if (hdr_acc) begin
        ld      = 1'b1;
        ld_data = merged;
        ld_keep = '1;
        res_d   = data_insert[RW-1:0];
        if (last_insert) state_d = DATA;
      end
      DATA: if (pay_acc) begin
        ld      = 1'b1;
        ld_data = merged;
        ld_keep = '1;
        res_d   = data_in[RW-1:0];
        if (last_in) begin
          if (sum <= CW'(N)) begin
            ld_keep = lead_ones(sum);
            ld_data = merged & byte_mask(lead_ones(sum));
            ld_last = 1'b1;
            r_d     = '0;
            state_d = IDLE;
          end else begin
            // Keep r: the spill is the first r+q-N of the beat's low r bytes.
            fcnt_d  = sum - CW'(N);
            state_d = FLUSH;
          end
        end
      end
      FLUSH: if (free) begin
        ld      = 1'b1;
        ld_keep = lead_ones(fcnt_q);
        ld_data = flushed & byte_mask(lead_ones(fcnt_q));
        ld_last = 1'b1;
        r_d     = '0;
        fcnt_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // NOTE: the residual is pure datapath; it is only read through r, which reset clears, so it needs no reset.
  always_ff @(posedge clk) begin
    res_q <= res_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      od_q <= '0;
      ok_q <= '0;
      ol_q <= 1'b0;
    end else if (ld) begin
      ov_q <= 1'b1;
      od_q <= ld_data;
      ok_q <= ld_keep;
      ol_q <= ld_last;
    end else if (ready_out) begin
      ov_q <= 1'b0;
      od_q <= '0;
      ok_q <= '0;
      ol_q <= 1'b0;
    end
  end

  assign valid_out = ov_q;
  assign data_out  = od_q;
  assign keep_out  = ok_q;
  assign last_out  = ol_q;

endmodule

// File: tb/tb_axi_stream_insert_header_mb.sv
// Self-checking bench: directed vector table, reset/stall sequences, and random
// back-to-back frames checked against a byte-level reference model.
`timescale 1ns/1ps

module tb_axi_stream_insert_header_mb;

  localparam int TIMEOUT = 1000;

  logic        clk, rst_n;
  logic        valid_in, last_in, ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        valid_insert, last_insert, ready_insert;
  logic [31:0] data_insert;
  logic [3:0]  keep_insert;
  logic [1:0]  byte_insert_cnt;
  logic        valid_out, last_out, ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;

  axi_stream_insert_header_mb dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .last_insert(last_insert), .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    int nh; logic [3:0][31:0] hd; logic [3:0][3:0] hk;
    int np; logic [3:0][31:0] pd; logic [3:0][3:0] pk;
    int no; logic [3:0][31:0] ed; logic [3:0][3:0] ek;
  } vec_t;

  beat_t hdr_q[$], pay_q[$], exp_q[$], got_q[$];
  vec_t  vecs[6];
  int    vectors, miscompares;
  int    stall_pct, gap_max;
  int    hdr_done, pay_done;
  logic  stalled;
  logic [36:0] held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    ready_out = 1'b0;
    forever begin
      @(posedge clk); #1;
      ready_out = ($urandom_range(0, 99) >= stall_pct);
    end
  end

  // Monitor: collects output beats, checks stall stability and payload gating.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled  = 1'b0;
      hdr_done = 0;
      pay_done = 0;
    end else begin
      if (stalled)
        check("stall_hold", {26'd0, valid_out, last_out, keep_out, data_out}, {26'd0, 1'b1, held});
      stalled = valid_out && !ready_out;
      held    = {last_out, keep_out, data_out};
      if (valid_in && ready_in) begin
        check("payload_before_header", 64'(hdr_done > pay_done), 64'd1);
        if (last_in) pay_done++;
      end
      if (valid_insert && ready_insert && last_insert) hdr_done++;
      if (valid_out && ready_out) begin
        beat_t g;
        g.d = data_out; g.k = keep_out; g.l = last_out;
        got_q.push_back(g);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_hdr_beat(input beat_t b);
    int n;
    n = 0;
    valid_insert = 1'b1; data_insert = b.d; keep_insert = b.k; last_insert = b.l;
    do begin @(negedge clk); n++; end while (!ready_insert && n < TIMEOUT);
    if (!ready_insert) check("hdr_handshake_timeout", 64'(ready_insert), 64'd1);
    @(posedge clk); #1;
    valid_insert = 1'b0; data_insert = $urandom(); keep_insert = '0; last_insert = 1'b0;
  endtask

  task automatic drive_pay_beat(input beat_t b);
    int n;
    n = 0;
    valid_in = 1'b1; data_in = b.d; keep_in = b.k; last_in = b.l;
    do begin @(negedge clk); n++; end while (!ready_in && n < TIMEOUT);
    if (!ready_in) check("pay_handshake_timeout", 64'(ready_in), 64'd1);
    @(posedge clk); #1;
    valid_in = 1'b0; data_in = $urandom(); keep_in = '0; last_in = 1'b0;
  endtask

  task automatic drive_hdrs();
    while (hdr_q.size() > 0) begin
      beat_t b;
      int g;
      b = hdr_q.pop_front();
      g = $urandom_range(0, gap_max);
      if (g > 0) begin repeat (g) @(posedge clk); #1; end
      drive_hdr_beat(b);
    end
  endtask

  task automatic drive_pays();
    while (pay_q.size() > 0) begin
      beat_t b;
      int g;
      b = pay_q.pop_front();
      g = $urandom_range(0, gap_max);
      if (g > 0) begin repeat (g) @(posedge clk); #1; end
      drive_pay_beat(b);
    end
  endtask

  task automatic run_and_compare(input string tag);
    int n, m;
    n = 0;
    got_q.delete();
    fork
      drive_hdrs();
      drive_pays();
    join
    while (got_q.size() < exp_q.size() && n < 2000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check({tag, " beat_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s beat%0d {d,k,l}", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    exp_q.delete();
    got_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic load_vec(input int v);
    beat_t b;
    for (int h = 0; h < vecs[v].nh; h++) begin
      b.d = vecs[v].hd[h]; b.k = vecs[v].hk[h]; b.l = (h == vecs[v].nh - 1);
      hdr_q.push_back(b);
    end
    for (int i = 0; i < vecs[v].np; i++) begin
      b.d = vecs[v].pd[i]; b.k = vecs[v].pk[i]; b.l = (i == vecs[v].np - 1);
      pay_q.push_back(b);
    end
    for (int o = 0; o < vecs[v].no; o++) begin
      b.d = vecs[v].ed[o]; b.k = vecs[v].ek[o]; b.l = (o == vecs[v].no - 1);
      exp_q.push_back(b);
    end
  endtask

  // Reference model: concatenate header and payload bytes, then cut into N-byte beats.
  task automatic gen_frame();
    logic [7:0]  bytes[$];
    logic [31:0] d;
    logic [3:0]  k;
    beat_t       b;
    int p, nhb, len, npb, rem, nb;
    p   = $urandom_range(1, 4);
    nhb = $urandom_range(1, 3);
    len = $urandom_range(1, 12);
    for (int h = 0; h < nhb; h++) begin
      d  = $urandom();
      nb = (h == 0) ? p : 4;
      k  = 4'hF;
      k  = k >> (4 - nb);
      b.d = d; b.k = k; b.l = (h == nhb - 1);
      hdr_q.push_back(b);
      for (int i = nb - 1; i >= 0; i--) bytes.push_back(d[8*i +: 8]);
    end
    npb = (len + 3) / 4;
    for (int j = 0; j < npb; j++) begin
      d   = $urandom();
      rem = (j == npb - 1) ? len - 4 * j : 4;
      k   = 4'hF;
      k   = k << (4 - rem);
      b.d = d; b.k = k; b.l = (j == npb - 1);
      pay_q.push_back(b);
      for (int i = 3; i >= 4 - rem; i--) bytes.push_back(d[8*i +: 8]);
    end
    while (bytes.size() > 0) begin
      b = '0;
      for (int i = 3; i >= 0; i--)
        if (bytes.size() > 0) begin b.d[8*i +: 8] = bytes.pop_front(); b.k[i] = 1'b1; end
      b.l = (bytes.size() == 0);
      exp_q.push_back(b);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; stall_pct = 0; gap_max = 0;
    rst_n = 1'b0; byte_insert_cnt = '0;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; keep_insert = '0; last_insert = 1'b0;

    // Short header, two payload beats, exact fit on the last beat.
    vecs[0].nh = 1; vecs[0].hd[0] = 32'hEEEEAABB; vecs[0].hk[0] = 4'b0011;
    vecs[0].np = 2; vecs[0].pd[0] = 32'h11223344; vecs[0].pk[0] = 4'b1111;
                    vecs[0].pd[1] = 32'h5566EEEE; vecs[0].pk[1] = 4'b1100;
    vecs[0].no = 2; vecs[0].ed[0] = 32'hAABB1122; vecs[0].ek[0] = 4'b1111;
                    vecs[0].ed[1] = 32'h33445566; vecs[0].ek[1] = 4'b1111;
    // Overflow into FLUSH.
    vecs[1].nh = 1; vecs[1].hd[0] = 32'hEEA1A2A3; vecs[1].hk[0] = 4'b0111;
    vecs[1].np = 1; vecs[1].pd[0] = 32'h11223344; vecs[1].pk[0] = 4'b1110;
    vecs[1].no = 2; vecs[1].ed[0] = 32'hA1A2A311; vecs[1].ek[0] = 4'b1111;
                    vecs[1].ed[1] = 32'h22330000; vecs[1].ek[1] = 4'b1100;
    // Multi-beat header.
    vecs[2].nh = 2; vecs[2].hd[0] = 32'hEEEEEEA0; vecs[2].hk[0] = 4'b0001;
                    vecs[2].hd[1] = 32'hA1A2A3A4; vecs[2].hk[1] = 4'b1111;
    vecs[2].np = 1; vecs[2].pd[0] = 32'hD0D1D2D3; vecs[2].pk[0] = 4'b1111;
    vecs[2].no = 3; vecs[2].ed[0] = 32'hA0A1A2A3; vecs[2].ek[0] = 4'b1111;
                    vecs[2].ed[1] = 32'hA4D0D1D2; vecs[2].ek[1] = 4'b1111;
                    vecs[2].ed[2] = 32'hD3000000; vecs[2].ek[2] = 4'b1000;
    // Full header beat: payload passes unshifted.
    vecs[3].nh = 1; vecs[3].hd[0] = 32'hC0C1C2C3; vecs[3].hk[0] = 4'b1111;
    vecs[3].np = 3; vecs[3].pd[0] = 32'h10111213; vecs[3].pk[0] = 4'b1111;
                    vecs[3].pd[1] = 32'h20212223; vecs[3].pk[1] = 4'b1111;
                    vecs[3].pd[2] = 32'h30EEEEEE; vecs[3].pk[2] = 4'b1000;
    vecs[3].no = 4; vecs[3].ed[0] = 32'hC0C1C2C3; vecs[3].ek[0] = 4'b1111;
                    vecs[3].ed[1] = 32'h10111213; vecs[3].ek[1] = 4'b1111;
                    vecs[3].ed[2] = 32'h20212223; vecs[3].ek[2] = 4'b1111;
                    vecs[3].ed[3] = 32'h30000000; vecs[3].ek[3] = 4'b1000;
    // Two header beats with r=3, then a one-byte FLUSH.
    vecs[4].nh = 2; vecs[4].hd[0] = 32'hEEB0B1B2; vecs[4].hk[0] = 4'b0111;
                    vecs[4].hd[1] = 32'hB3B4B5B6; vecs[4].hk[1] = 4'b1111;
    vecs[4].np = 1; vecs[4].pd[0] = 32'h9192EEEE; vecs[4].pk[0] = 4'b1100;
    vecs[4].no = 2; vecs[4].ed[0] = 32'hB0B1B2B3; vecs[4].ek[0] = 4'b1111;
                    vecs[4].ed[1] = 32'h92000000; vecs[4].ek[1] = 4'b1000;
    // Minimal frame: one header byte and one payload byte.
    vecs[5].nh = 1; vecs[5].hd[0] = 32'hEEEEEE77; vecs[5].hk[0] = 4'b0001;
    vecs[5].np = 1; vecs[5].pd[0] = 32'h88EEEEEE; vecs[5].pk[0] = 4'b1000;
    vecs[5].no = 1; vecs[5].ed[0] = 32'h77880000; vecs[5].ek[0] = 4'b1100;
    // vecs[4] spills B4B5B6 91 as its full beat; insert it between the two listed beats.
    vecs[4].no = 3; vecs[4].ed[2] = 32'h92000000; vecs[4].ek[2] = 4'b1000;
                    vecs[4].ed[1] = 32'hB4B5B691; vecs[4].ek[1] = 4'b1111;

    // Reset values.
    #12;
    check("rst outputs", {26'd0, valid_out, last_out, keep_out, data_out}, 64'd0);
    check("rst ready_in", 64'(ready_in), 64'd0);
    check("rst ready_insert", 64'(ready_insert), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #2;
    check("post-rst ready_insert", 64'(ready_insert), 64'd1);
    check("post-rst ready_in", 64'(ready_in), 64'd0);

    // Directed table, first unthrottled, then with stalls and gaps.
    for (int pass = 0; pass < 2; pass++) begin
      stall_pct = (pass == 0) ? 0 : 30;
      gap_max   = (pass == 0) ? 0 : 2;
      for (int v = 0; v < 6; v++) begin
        load_vec(v);
        run_and_compare($sformatf("pass%0d vec%0d", pass, v));
      end
    end

    // Reset mid-frame with a beat held in the output register.
    stall_pct = 100;
    repeat (2) @(posedge clk); #1;
    begin
      beat_t b;
      b.d = 32'hCAFEF00D; b.k = 4'hF; b.l = 1'b1;
      drive_hdr_beat(b);
    end
    @(negedge clk);
    check("midframe valid_out", 64'(valid_out), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midframe rst outputs", {26'd0, valid_out, last_out, keep_out, data_out}, 64'd0);
    check("midframe rst readies", {62'd0, ready_in, ready_insert}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; stall_pct = 0;
    @(posedge clk); #2;
    check("midframe post-rst ready_insert", 64'(ready_insert), 64'd1);
    got_q.delete();
    load_vec(2);
    run_and_compare("after-reset vec2");

    // Randomised back-to-back frames against the byte-level model.
    stall_pct = 20;
    gap_max   = 2;
    for (int f = 0; f < 50; f++) gen_frame();
    run_and_compare("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
